// File: rtl/prim_cipher_pkg.sv
// Shared lightweight-cipher constants used by the substitution/permutation primitives.
package prim_cipher_pkg;

  // Inverse PRESENT 4-bit S-box, entry [i] is the preimage of nibble i.
  parameter logic [15:0][3:0] PRESENT_SBOX4_INV = {4'hA, 4'h9, 4'h7, 4'h0,
                                                   4'h3, 4'h6, 4'h4, 4'hB,
                                                   4'hD, 4'h2, 4'h1, 4'hC,
                                                   4'h8, 4'hF, 4'hE, 4'h5};

endpackage

// File: rtl/prim_subst_perm_dec_iter_pkg.sv
// Helpers shared by the iterative substitution/permutation decrypter and its round logic.
package prim_subst_perm_dec_iter_pkg;
   import prim_cipher_pkg::*;

   localparam int unsigned SboxWidth = 4;

   function automatic logic [SboxWidth-1:0] sbox4_inv(input logic [SboxWidth-1:0] nib);
      return PRESENT_SBOX4_INV[nib];
   endfunction

endpackage

// File: rtl/prim_subst_perm_dec_iter_if.sv
// Input/output handshake bundle of the iterative substitution/permutation decrypter.
interface prim_subst_perm_dec_iter_if #(
   parameter int unsigned DataWidth = 64
);
   logic                 valid_i;
   logic                 ready_o;
   logic [DataWidth-1:0] data_i;
   logic [DataWidth-1:0] key_i;
   logic                 valid_o;
   logic                 ready_i;
   logic [DataWidth-1:0] data_o;

   modport master (
      output valid_i, data_i, key_i, ready_i,
      input  ready_o, valid_o, data_o
   );

   modport slave (
      input  valid_i, data_i, key_i, ready_i,
      output ready_o, valid_o, data_o
   );

endinterface

// File: rtl/prim_subst_perm_dec_round.sv
// One combinational inverse round: key XOR, un-regroup, bit-reverse, inverse S-box layer.
module prim_subst_perm_dec_round
   import prim_subst_perm_dec_iter_pkg::*;
#(
   parameter int unsigned DataWidth = 64
) (
   input  logic [DataWidth-1:0] data_i,
   input  logic [DataWidth-1:0] key_i,
   output logic [DataWidth-1:0] data_o
);

   localparam int unsigned Half       = DataWidth / 2;
   localparam int unsigned NumNibbles = DataWidth / SboxWidth;
   localparam int unsigned SboxBits   = NumNibbles * SboxWidth;

   logic [DataWidth-1:0] y;
   logic [DataWidth-1:0] f;
   logic [DataWidth-1:0] z;

   assign y = data_i ^ key_i;

   // Interleave lower and upper halves back into even/odd bit positions.
   for (genvar k = 0; k < Half; k++) begin : g_unregroup
      assign f[2*k]   = y[k];
      assign f[2*k+1] = y[k+Half];
   end
   if (DataWidth % 2 == 1) begin : g_odd_msb
      assign f[DataWidth-1] = y[DataWidth-1];
   end

   for (genvar k = 0; k < DataWidth; k++) begin : g_reverse
      assign z[DataWidth-1-k] = f[k];
   end

   for (genvar k = 0; k < NumNibbles; k++) begin : g_sbox
      assign data_o[SboxWidth*k +: SboxWidth] = sbox4_inv(z[SboxWidth*k +: SboxWidth]);
   end
   if (SboxBits < DataWidth) begin : g_partial_nibble
      assign data_o[DataWidth-1:SboxBits] = z[DataWidth-1:SboxBits];
   end

endmodule

// File: rtl/prim_subst_perm_dec_iter.sv
// Iterative handshaked inverse of the substitution/permutation diffusion primitive,
// one inverse round per clock.
module prim_subst_perm_dec_iter
   import prim_subst_perm_dec_iter_pkg::*;
#(
   parameter int unsigned DataWidth = 64,
   parameter int unsigned NumRounds = 31
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        clr_i,
   prim_subst_perm_dec_iter_if.slave   bus
);

   localparam int unsigned     CntW    = $clog2(NumRounds + 1);
   localparam logic [CntW-1:0] LastRnd = CntW'(NumRounds);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} fsm_e;

   fsm_e                 fsm_q, fsm_d;
   logic [DataWidth-1:0] state_q, state_d;
   logic [DataWidth-1:0] key_q, key_d;
   logic [DataWidth-1:0] round_out;
   logic [CntW-1:0]      rnd_q, rnd_d, rnd_inc;
   logic                 accept;

   prim_subst_perm_dec_round #(
      .DataWidth (DataWidth)
   ) u_round (
      .data_i (state_q),
      .key_i  (key_q),
      .data_o (round_out)
   );

   assign rnd_inc = rnd_q + CntW'(1);

   // Gate ready with clr so an abort never looks like an accepted word upstream.
   assign bus.ready_o = (fsm_q == StIdle) && !clr_i && !rst_i;
   assign bus.valid_o = (fsm_q == StDone);
   assign bus.data_o  = state_q ^ key_q;
   assign accept      = bus.valid_i && bus.ready_o;

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      key_d   = key_q;
      rnd_d   = rnd_q;

      unique case (fsm_q)
         StIdle: begin
            if (accept) begin
               state_d = bus.data_i;
               key_d   = bus.key_i;
               rnd_d   = '0;
               fsm_d   = StBusy;
            end
         end
         StBusy: begin
            state_d = round_out;
            rnd_d   = rnd_inc;
            if (rnd_inc == LastRnd) begin
               fsm_d = StDone;
            end
         end
         StDone: begin
            if (bus.ready_i) begin
               fsm_d = StIdle;
            end
         end
         default: fsm_d = StIdle;
      endcase

      if (clr_i) begin
         fsm_d = StIdle;
         rnd_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fsm_q   <= StIdle;
         state_q <= '0;
         key_q   <= '0;
         rnd_q   <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         key_q   <= key_d;
         rnd_q   <= rnd_d;
      end
   end

endmodule

// File: doc/prim_subst_perm_dec_iter.md
# prim_subst_perm_dec_iter

Iterative, handshaked inverse of the substitution/permutation diffusion primitive. It recovers the original data from a diffused word and the same key, computing one inverse round per clock. It serves area-constrained consumers, such as scrambled-memory readback and debug unscrambling, where a fully unrolled combinational decrypter is too large. It is not cryptographically secure; it provides diffusion only.

## Interface
Parameters:
- DataWidth, 64: word width; any value ≥ 4, odd widths allowed.
- NumRounds, 31: inverse rounds per transaction; ≥ 1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- clr_i  in  1  synchronous abort; returns the block to IDLE.
- valid_i  in  1  input word valid.
- ready_o  out  1  block can accept an input word.
- data_i  in  DataWidth  diffused (encrypted) word.
- key_i  in  DataWidth  key; sampled only on the input handshake.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- data_o  out  DataWidth  recovered word.

## Operation
- Registers:
  - state_q, DataWidth bits.
  - key_q, DataWidth bits.
  - rnd_q, counter of $clog2(NumRounds+1) bits.
  - FSM with states IDLE, BUSY, DONE.
- Inverse round R(x), applied to y = x ^ key_q:
  - Un-regroup: start with f = y; for k < DataWidth/2, set f[2k] = y[k] and f[2k+1] = y[k+DataWidth/2]. For odd widths the MSB stays in place.
  - Bit-reverse: z[DataWidth-1-k] = f[k].
  - Inverse S-box: apply PRESENT_SBOX4_INV to each full nibble z[4k+:4] for k < DataWidth/4. Leftover upper bits pass through unchanged.
- Output: data_o = state_q ^ key_q.
- Correctness: for any key K and word D, decrypting the encrypt-direction output E(D,K) with key K yields D.
- IDLE:
  - ready_o = 1.
  - On valid_i && ready_o: state_q ← data_i, key_q ← key_i, rnd_q ← 0, go to BUSY.
- BUSY:
  - ready_o = 0.
  - Each cycle: state_q ← R(state_q), rnd_q ← rnd_q + 1.
  - When the update makes rnd_q reach NumRounds, go to DONE.
- DONE:
  - valid_o = 1; data_o is held stable.
  - On ready_i: go to IDLE.
  - No new input is accepted in the same cycle as the output handshake.
- valid_o is high only in DONE.
- Abort: clr_i in any state forces IDLE and rnd_q ← 0. clr_i takes priority over both handshakes in the same cycle; a result being offered is dropped.
- Reset: rst_i has priority over clr_i. All registers clear to 0 and the FSM goes to IDLE.

## Timing
- Reset values:
  - valid_o = 0.
  - ready_o = 1 in the first cycle after reset deassertion (ready_o is 0 while rst_i is asserted).
  - data_o = 0.
- Latency: input handshake at edge T; rounds execute at edges T+1 … T+NumRounds; valid_o rises in the cycle after edge T+NumRounds. That is NumRounds+1 cycles from input handshake to result valid.
- Throughput: one word per NumRounds+2 cycles when ready_i is held high.
- Handshake rules:
  - ready_o must not depend combinationally on valid_i.
  - valid_o must not depend combinationally on ready_i.
  - valid_o and data_o stay stable while valid_o && !ready_i.
- Changes on key_i or data_i outside the input handshake have no effect.
- rnd_q never exceeds NumRounds; it does not wrap.
- Single-cycle critical path: one XOR, wiring, and one 4-bit S-box lookup.

## Structure
- PRESENT_SBOX4_INV comes from prim_cipher_pkg; do not add new S-box tables.
- The FSM state enum is local to the module; no new package typedefs.
- One combinational sub-module, prim_subst_perm_dec_round, takes data and key and returns R(data). Parameters: DataWidth.
- Top level contains the FSM, counter, and registers only.

## Test plan
- DataWidth=4, NumRounds=1, data_i=0x0, key_i=0x0 → valid_o two cycles after the handshake, data_o=0x5.
- DataWidth=4, NumRounds=1, data_i=0xC, key_i=0x0 → data_o=0x1. Check that ready_o is low for two cycles, then stays low until ready_i.
- Defaults, 1000 random (D,K) pairs: feed the bench's encrypt-direction model output → data_o == D. ready_i is randomly stalled; data_o is checked for stability while stalled.
- clr_i pulsed at round 10 → next cycle ready_o=1, valid_o=0. The next transaction produces a correct result.
- rst_i asserted during DONE with ready_i=0 → next cycle valid_o=0, data_o=0, ready_o=1.
- DataWidth=7, NumRounds=5, random pairs → round-trip equals the input, covering odd width and the partial nibble.
